// File: rtl/coh_pkg.sv
// coh_pkg: coherence message codes, block-state encoding and message helpers
// shared by the cache block controller and the directory controller.
package coh_pkg;

    localparam int CODE_W = 6;
    localparam int ADDR_W = 16;
    localparam int MSG_W  = CODE_W + ADDR_W;

    // Situation codes carried in bits [21:16] of every message.
    localparam logic [CODE_W-1:0] SIT_WR_MISS    = 6'b000000;
    localparam logic [CODE_W-1:0] SIT_RD_MISS    = 6'b000001;
    localparam logic [CODE_W-1:0] SIT_INVALIDATE = 6'b000100;
    localparam logic [CODE_W-1:0] SIT_DATA_WB    = 6'b000101;
    localparam logic [CODE_W-1:0] SIT_DATA_REPLY = 6'b000110;
    localparam logic [CODE_W-1:0] SIT_FETCH      = 6'b100111;

    // Internal block states; both pending flavours report as 2'b11.
    typedef enum logic [2:0] {
        BLK_I       = 3'd0,
        BLK_S       = 3'd1,
        BLK_M       = 3'd2,
        BLK_RD_PEND = 3'd3,
        BLK_WR_PEND = 3'd4
    } blk_state_e;

    function automatic logic [1:0] state_code(input blk_state_e s);
        case (s)
            BLK_I:   return 2'b00;
            BLK_S:   return 2'b01;
            BLK_M:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic is_pending(input blk_state_e s);
        return (s == BLK_RD_PEND) || (s == BLK_WR_PEND);
    endfunction

    // Miss code that a pending state re-issues on watchdog expiry.
    function automatic logic [CODE_W-1:0] miss_code(input blk_state_e s);
        return (s == BLK_RD_PEND) ? SIT_RD_MISS : SIT_WR_MISS;
    endfunction

    function automatic logic [MSG_W-1:0] pack_msg(input logic [CODE_W-1:0] code,
                                                  input logic [ADDR_W-1:0] addr);
        return {code, addr};
    endfunction

endpackage

// File: rtl/cdb_tx_reg.sv
// cdb_tx_reg: outbound message hold register. A loaded message stays stable
// and valid until the cycle ready is seen; withdraw drops it unsent.
module cdb_tx_reg
    import coh_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [MSG_W-1:0] load_msg,
    input  logic             withdraw,
    output logic [MSG_W-1:0] cdb_out,
    output logic             cdb_out_valid,
    input  logic             cdb_out_ready
);

    logic [MSG_W-1:0] msg_reg;
    logic             valid_reg;

    // Hold register: withdraw beats load, load beats the handshake drop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            msg_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (withdraw) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            msg_reg   <= load_msg;
            valid_reg <= 1'b1;
        end else if (valid_reg && cdb_out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign cdb_out       = msg_reg;
    assign cdb_out_valid = valid_reg;

endmodule

// File: rtl/cache_block_fsm.sv
// cache_block_fsm: single-block MSI cache controller talking to a directory.
// Define CACHE_FSM_STATS_EN to add saturating hit_count / miss_count outputs.
// Watchdog: a pending miss is re-sent after TIMEOUT_CYC consecutive cycles
// with no outbound message outstanding.
module cache_block_fsm
    import coh_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_write,
    input  logic              cpu_req_evict,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_done,
    output logic [1:0]        state,
    output logic [MSG_W-1:0]  cdb_out,
    output logic              cdb_out_valid,
    input  logic              cdb_out_ready,
    input  logic [MSG_W-1:0]  dir_msg,
    input  logic              dir_msg_valid
`ifdef CACHE_FSM_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int              WD_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    blk_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] blk_addr_reg, blk_addr_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic              cpu_done_reg, cpu_done_next;
    logic              tx_load, tx_withdraw;
    logic [MSG_W-1:0]  tx_msg;
    logic              pending, accept, req_hit, req_miss, dir_match, reply_hit;
    logic [CODE_W-1:0] dir_code;

    // Request decode; a directory message in the same cycle blocks the CPU.
    assign pending       = is_pending(state_reg);
    assign cpu_req_ready = !pending && !cdb_out_valid && !dir_msg_valid;
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign req_hit       = accept && !cpu_req_evict &&
                           (cpu_req_write ? (state_reg == BLK_M) : (state_reg != BLK_I));
    assign req_miss      = accept && !cpu_req_evict && !req_hit;
    assign dir_code      = dir_msg[MSG_W-1:ADDR_W];
    assign dir_match     = dir_msg_valid && (dir_msg[ADDR_W-1:0] == blk_addr_reg);
    assign reply_hit     = dir_match && pending && (dir_code == SIT_DATA_REPLY);
    assign state         = state_code(state_reg);
    assign cpu_done      = cpu_done_reg;

    // Next-state, watchdog and outbound-message decisions.
    always_comb begin
        state_next    = state_reg;
        blk_addr_next = blk_addr_reg;
        wd_cnt_next   = wd_cnt_reg;
        cpu_done_next = 1'b0;
        tx_load       = 1'b0;
        tx_withdraw   = 1'b0;
        tx_msg        = pack_msg(SIT_DATA_WB, blk_addr_reg);
        if (reply_hit) begin
            // A still-unsent miss is pulled back; the reply completes the request.
            state_next    = (state_reg == BLK_RD_PEND) ? BLK_S : BLK_M;
            cpu_done_next = 1'b1;
            tx_withdraw   = cdb_out_valid;
        end else if (pending) begin
            if (cdb_out_valid) begin
                wd_cnt_next = '0;
            end else if (wd_cnt_reg == WD_LAST) begin
                wd_cnt_next = '0;
                tx_load     = 1'b1;
                tx_msg      = pack_msg(miss_code(state_reg), blk_addr_reg);
            end else begin
                wd_cnt_next = wd_cnt_reg + 1'b1;
            end
        end else if (dir_match && (state_reg == BLK_S) && (dir_code == SIT_INVALIDATE)) begin
            state_next = BLK_I;
        end else if (dir_match && (state_reg == BLK_M) && (dir_code == SIT_FETCH)) begin
            tx_load    = 1'b1;
            state_next = BLK_S;
        end else if (accept) begin
            if (cpu_req_evict) begin
                blk_addr_next = cpu_req_addr;
                cpu_done_next = 1'b1;
                state_next    = BLK_I;
                if (state_reg == BLK_M) begin
                    tx_load = 1'b1;
                    tx_msg  = pack_msg(SIT_DATA_WB, cpu_req_addr);
                end
            end else if (req_hit) begin
                cpu_done_next = 1'b1;
            end else if (req_miss) begin
                blk_addr_next = cpu_req_addr;
                wd_cnt_next   = '0;
                tx_load       = 1'b1;
                tx_msg        = pack_msg(cpu_req_write ? SIT_WR_MISS : SIT_RD_MISS, cpu_req_addr);
                state_next    = cpu_req_write ? BLK_WR_PEND : BLK_RD_PEND;
            end
        end
    end

    // State, block address, watchdog and completion-pulse registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= BLK_I;
            blk_addr_reg <= '0;
            wd_cnt_reg   <= '0;
            cpu_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            blk_addr_reg <= blk_addr_next;
            wd_cnt_reg   <= wd_cnt_next;
            cpu_done_reg <= cpu_done_next;
        end
    end

    cdb_tx_reg u_tx (
        .clock         (clock),
        .reset_n       (reset_n),
        .load          (tx_load),
        .load_msg      (tx_msg),
        .withdraw      (tx_withdraw),
        .cdb_out       (cdb_out),
        .cdb_out_valid (cdb_out_valid),
        .cdb_out_ready (cdb_out_ready)
    );

`ifdef CACHE_FSM_STATS_EN
    logic [1:0] stat_evt;
    assign stat_evt = {req_miss, req_hit};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        // Saturating event counter; watchdog re-sends never raise req_miss.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                cnt_reg <= '0;
            end else if (stat_evt[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign hit_count  = g_stat[0].cnt_reg;
    assign miss_count = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_cache_block_fsm.sv
// tb_cache_block_fsm: directed scenarios with literal expectations, then
// randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_cache_block_fsm;

    localparam int TMO = 8;
    localparam logic [5:0] C_WR    = 6'b000000;
    localparam logic [5:0] C_RD    = 6'b000001;
    localparam logic [5:0] C_INV   = 6'b000100;
    localparam logic [5:0] C_WB    = 6'b000101;
    localparam logic [5:0] C_REPLY = 6'b000110;
    localparam logic [5:0] C_FETCH = 6'b100111;

    logic        clock = 1'b0;
    logic        reset_n, cpu_req_valid, cpu_req_write, cpu_req_evict;
    logic [15:0] cpu_req_addr;
    logic        cpu_req_ready, cpu_done;
    logic [1:0]  state;
    logic [21:0] cdb_out;
    logic        cdb_out_valid, cdb_out_ready;
    logic [21:0] dir_msg;
    logic        dir_msg_valid;
`ifdef CACHE_FSM_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cache_block_fsm #(.TIMEOUT_CYC(TMO)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_write (cpu_req_write),
        .cpu_req_evict (cpu_req_evict),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_ready (cpu_req_ready),
        .cpu_done      (cpu_done),
        .state         (state),
        .cdb_out       (cdb_out),
        .cdb_out_valid (cdb_out_valid),
        .cdb_out_ready (cdb_out_ready),
        .dir_msg       (dir_msg),
        .dir_msg_valid (dir_msg_valid)
`ifdef CACHE_FSM_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    // Model: 0=I 1=S 2=M 3=read pending 4=write pending.
    int          m_st = 0;
    logic [15:0] m_blk = '0;
    logic        m_v = 1'b0;
    logic [21:0] m_msg = '0;
    int          m_gap = 0;
    logic        m_done = 1'b0;
    int          m_hits = 0;
    int          m_misses = 0;
    bit          m_init = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model advanced on every rising edge from the driven inputs.
    always @(posedge clock) begin : model_p
        int st, gap, hc, mc;
        logic [15:0] blk;
        logic v, done, match, rdy, reply;
        logic [21:0] msg;
        logic [5:0] code;
        st = m_st; blk = m_blk; v = m_v; msg = m_msg; gap = m_gap;
        hc = m_hits; mc = m_misses; done = 1'b0;
        if (!reset_n) begin
            st = 0; blk = '0; v = 1'b0; msg = '0; gap = 0; hc = 0; mc = 0;
            m_init <= 1'b1;
        end else begin
            code  = dir_msg[21:16];
            match = dir_msg_valid && (dir_msg[15:0] == m_blk);
            rdy   = (m_st < 3) && !m_v && !dir_msg_valid;
            reply = match && (code == C_REPLY) && (m_st >= 3);
            if (m_v && cdb_out_ready) v = 1'b0;
            if (reply) begin
                st = (m_st == 3) ? 1 : 2; done = 1'b1; v = 1'b0;
            end else if (match && code == C_INV && m_st == 1) begin
                st = 0;
            end else if (match && code == C_FETCH && m_st == 2) begin
                st = 1; v = 1'b1; msg = {C_WB, m_blk};
            end else if (m_st >= 3) begin
                if (m_v) gap = 0;
                else begin
                    gap = gap + 1;
                    if (gap == TMO) begin
                        gap = 0; v = 1'b1; msg = {(m_st == 3) ? C_RD : C_WR, m_blk};
                    end
                end
            end
            if (cpu_req_valid && rdy) begin
                if (cpu_req_evict) begin
                    done = 1'b1; blk = cpu_req_addr; st = 0;
                    if (m_st == 2) begin v = 1'b1; msg = {C_WB, cpu_req_addr}; end
                end else if (cpu_req_write ? (m_st == 2) : (m_st != 0)) begin
                    done = 1'b1; if (hc < 65535) hc = hc + 1;
                end else begin
                    blk = cpu_req_addr; st = cpu_req_write ? 4 : 3; gap = 0;
                    v = 1'b1; msg = {cpu_req_write ? C_WR : C_RD, cpu_req_addr};
                    if (mc < 65535) mc = mc + 1;
                end
            end
        end
        m_st <= st; m_blk <= blk; m_v <= v; m_msg <= msg; m_gap <= gap;
        m_done <= done; m_hits <= hc; m_misses <= mc;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        #2;
        if (m_init) begin
            chk("state", 32'(state), (m_st >= 3) ? 32'd3 : 32'(m_st));
            chk("cdb_out_valid", 32'(cdb_out_valid), 32'(m_v));
            if (m_v) chk("cdb_out", 32'(cdb_out), 32'(m_msg));
            chk("cpu_done", 32'(cpu_done), 32'(m_done));
            chk("cpu_req_ready", 32'(cpu_req_ready), 32'((m_st < 3) && !m_v && !dir_msg_valid));
`ifdef CACHE_FSM_STATS_EN
            chk("hit_count", 32'(hit_count), 32'(m_hits));
            chk("miss_count", 32'(miss_count), 32'(m_misses));
`endif
        end
    end

    task automatic cyc();
        @(negedge clock);
        #3;
    endtask

    task automatic req(input logic wr, input logic ev, input logic [15:0] addr);
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_evict = ev; cpu_req_addr = addr;
        cyc();
        cpu_req_valid = 1'b0;
    endtask

    task automatic dir(input logic [5:0] code, input logic [15:0] addr);
        dir_msg = {code, addr}; dir_msg_valid = 1'b1;
        cyc();
        dir_msg_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_evict = 1'b0;
        cpu_req_addr = '0; cdb_out_ready = 1'b1; dir_msg = '0; dir_msg_valid = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(cdb_out_valid), 32'd0);
        chk("rst_cdb_out", 32'(cdb_out), 32'd0);
        chk("rst_done", 32'(cpu_done), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Read miss then reply.
        req(1'b0, 1'b0, 16'h1234);
        chk("rdmiss_state", 32'(state), 32'd3);
        chk("rdmiss_msg", 32'(cdb_out), 32'h011234);
        chk("rdmiss_valid", 32'(cdb_out_valid), 32'd1);
        dir(C_REPLY, 16'h1234);
        chk("rdreply_state", 32'(state), 32'd1);
        chk("rdreply_done", 32'(cpu_done), 32'd1);
        cyc();
        chk("done_pulse_len", 32'(cpu_done), 32'd0);

        // Write upgrade from S, then directory fetch.
        req(1'b1, 1'b0, 16'h1234);
        chk("wrmiss_msg", 32'(cdb_out), 32'h001234);
        dir(C_REPLY, 16'h1234);
        chk("wrreply_state", 32'(state), 32'd2);
        dir(C_FETCH, 16'h1234);
        chk("fetch_msg", 32'(cdb_out), 32'h051234);
        chk("fetch_valid", 32'(cdb_out_valid), 32'd1);
        chk("fetch_state", 32'(state), 32'd1);
        cyc();
        dir(C_INV, 16'h9999);
        chk("inv_nomatch_state", 32'(state), 32'd1);
        dir(C_INV, 16'h1234);
        chk("inv_match_state", 32'(state), 32'd0);

        // Back-pressure hold, then watchdog re-send.
        cdb_out_ready = 1'b0;
        req(1'b0, 1'b0, 16'h00AB);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_valid", 32'(cdb_out_valid), 32'd1);
            chk("hold_msg", 32'(cdb_out), 32'h0100AB);
        end
        cdb_out_ready = 1'b1;
        cyc();
        chk("hs_valid_drop", 32'(cdb_out_valid), 32'd0);
        for (int i = 1; i < TMO; i++) begin
            cyc();
            chk("wd_idle_valid", 32'(cdb_out_valid), 32'd0);
        end
        cyc();
        chk("wd_resend_valid", 32'(cdb_out_valid), 32'd1);
        chk("wd_resend_msg", 32'(cdb_out), 32'h0100AB);
        dir(C_REPLY, 16'h00AB);
        chk("wd_reply_state", 32'(state), 32'd1);

        // Directory message blocks a same-cycle request; reset in WR_PEND.
        cpu_req_valid = 1'b1; cpu_req_write = 1'b1; cpu_req_evict = 1'b0; cpu_req_addr = 16'h00AB;
        dir_msg = {6'h3F, 16'h00AB}; dir_msg_valid = 1'b1;
        #1;
        chk("blocked_ready", 32'(cpu_req_ready), 32'd0);
        cyc();
        chk("blocked_state", 32'(state), 32'd1);
        dir_msg_valid = 1'b0; cdb_out_ready = 1'b0;
        cyc();
        cpu_req_valid = 1'b0;
        chk("wrpend_state", 32'(state), 32'd3);
        reset_n = 1'b0;
        cyc();
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_valid", 32'(cdb_out_valid), 32'd0);
        reset_n = 1'b1; cdb_out_ready = 1'b1;
        cyc();

        // Hit/miss counting, including a watchdog re-send.
        req(1'b0, 1'b0, 16'h0001);
        dir(C_REPLY, 16'h0001);
        req(1'b0, 1'b0, 16'h5555);
        chk("hit_done", 32'(cpu_done), 32'd1);
        req(1'b0, 1'b0, 16'h0001);
        req(1'b1, 1'b0, 16'h0001);
        repeat (TMO + 1) cyc();
        chk("wd2_valid", 32'(cdb_out_valid), 32'd1);
        chk("wd2_msg", 32'(cdb_out), 32'h000001);
        dir(C_REPLY, 16'h0001);
        req(1'b1, 1'b0, 16'h7777);
        chk("wrhit_state", 32'(state), 32'd2);
`ifdef CACHE_FSM_STATS_EN
        chk("stat_hits", 32'(hit_count), 32'd3);
        chk("stat_misses", 32'(miss_count), 32'd2);
`endif
        cyc();
        req(1'b0, 1'b1, 16'h0001);
        chk("evict_msg", 32'(cdb_out), 32'h050001);
        chk("evict_state", 32'(state), 32'd0);
        chk("evict_done", 32'(cpu_done), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] addrs [3];
            logic [5:0]  codes [6];
            addrs[0] = 16'h1234; addrs[1] = 16'h00AB; addrs[2] = 16'h9999;
            codes[0] = C_REPLY; codes[1] = C_REPLY; codes[2] = C_INV;
            codes[3] = C_FETCH; codes[4] = 6'h3F;   codes[5] = C_RD;
            cpu_req_valid = ($urandom_range(0, 2) == 0);
            cpu_req_write = $urandom_range(0, 1) == 1;
            cpu_req_evict = ($urandom_range(0, 5) == 0);
            cpu_req_addr  = addrs[$urandom_range(0, 2)];
            dir_msg       = {codes[$urandom_range(0, 5)], addrs[$urandom_range(0, 2)]};
            dir_msg_valid = ($urandom_range(0, 4) == 0);
            cdb_out_ready = ($urandom_range(0, 2) != 0);
            reset_n       = ($urandom_range(0, 199) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_block_fsm.md
CACHE_BLOCK_FSM -- requirements
Module: cache_block_fsm

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, cycles spent in a pending state before the outstanding miss is re-issued.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 cpu_req_valid  input  1  processor request present.
REQ-005 cpu_req_write  input  1  1=write, 0=read; ignored when cpu_req_evict=1.
REQ-006 cpu_req_evict  input  1  request is an eviction of the held block.
REQ-007 cpu_req_addr  input  16  block address of the request.
REQ-008 cpu_req_ready  output  1  combinational; high only in a stable state (I/S/M) with cdb_out_valid=0 and dir_msg_valid=0.
REQ-009 cpu_done  output  1  one-cycle pulse when the accepted request completes.
REQ-010 state  output  2  block state: 00=Invalid, 01=Shared, 10=Modified, 11=pending (busy).
REQ-011 cdb_out  output  22  message to directory: [21:16] situation code, [15:0] block address.
REQ-012 cdb_out_valid / cdb_out_ready  output / input  1 / 1  outbound valid/ready handshake.
REQ-013 dir_msg  input  22  message from directory, same format as cdb_out.
REQ-014 dir_msg_valid  input  1  dir_msg valid this cycle; no back-pressure.

Function
REQ-015 Situation codes: write miss 000000, read miss 000001, invalidate 000100, data write-back 000101, data reply 000110, fetch 100111.
REQ-016 Request accepted on cpu_req_valid && cpu_req_ready; cpu_req_addr latched into blk_addr, except on read/write hits, where blk_addr is unchanged.
REQ-017 Hit: read in S or M, or write in M; cpu_done pulses the cycle after acceptance, no message, state unchanged.
REQ-018 Read in I: send read miss with latched address; enter RD_PEND.
REQ-019 Write in I or S: send write miss with latched address; enter WR_PEND.
REQ-020 Evict: M sends data write-back and goes I; S goes I silently; I is a no-op; cpu_done pulses the cycle after acceptance in all three cases.
REQ-021 cdb_out and cdb_out_valid are registered; once valid, the message is held stable until the cycle cdb_out_ready=1, then cdb_out_valid drops the next edge.
REQ-022 RD_PEND/WR_PEND exit only on dir_msg_valid with code data reply and dir_msg[15:0]==blk_addr: RD_PEND goes S, WR_PEND goes M, cpu_done pulses the same edge.
REQ-023 Data reply received while the miss is still un-handshaken: the miss is withdrawn (cdb_out_valid cleared) and the reply is honoured.
REQ-024 Invalidate matching blk_addr: S goes I; ignored in I, M and pending states.
REQ-025 Fetch matching blk_addr in M: send data write-back with blk_addr; go S; ignored in all other states.
REQ-026 Messages with non-matching address or unknown code are ignored.
REQ-027 Pending watchdog: counter clears on entering a pending state; on reaching TIMEOUT_CYC with cdb_out_valid=0, the same miss is re-sent and the counter clears.
REQ-028 A directory message and a CPU request in the same cycle: the directory message is processed and the request is not accepted (cpu_req_ready=0).

Reset
REQ-029 reset_n=0 at an edge: state I, blk_addr 0, cdb_out 0, cdb_out_valid 0, cpu_done 0, watchdog 0, counters 0.
REQ-030 Reset mid-operation abandons any pending miss or unacknowledged message without completing the handshake.

Configuration
REQ-031 CACHE_FSM_STATS_EN defined: outputs hit_count[15:0] and miss_count[15:0] are present; each increments once per hit or miss issued (re-sends excluded) and saturates at 16'hFFFF.
REQ-032 CACHE_FSM_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-033 Package coh_pkg holds the situation-code constants, the state encoding and the message-pack helper; the directory state machine uses the same package.
REQ-034 The outbound hold register with its valid/ready logic is sub-module cdb_tx_reg.

Verification
REQ-035 Reset; read addr 0x1234 in I -> cdb_out {000001,0x1234}; reply {000110,0x1234} -> state 01, cpu_done 1 cycle.
REQ-036 In S at 0x1234, write -> write miss sent; reply -> state 10; then dir fetch {100111,0x1234} -> cdb_out {000101,0x1234}, state 01.
REQ-037 Hold cdb_out_ready=0 for 5 cycles after a miss -> cdb_out unchanged and valid throughout; ready=1 -> valid drops next cycle.
REQ-038 TIMEOUT_CYC=8, no reply -> identical miss re-sent 8 cycles after handshake; invalidate {000100,0x9999} in S@0x1234 -> ignored.
REQ-039 Request and dir_msg_valid in the same cycle -> request not accepted; reset asserted in WR_PEND -> state 00, cdb_out_valid 0 next edge.
REQ-040 With CACHE_FSM_STATS_EN: 3 hits and 2 misses -> hit_count 3, miss_count 2; a watchdog re-send does not change miss_count.
